enigma_rotor_engine: RTL and testbench

Parametrised, clocked successor to the combinational breadboard stage. Implements an N-rotor, 2^W-symbol Enigma-style substitution cipher with per-symbol rotor stepping, a fixed-point-free reflector and a valid/ready stream interface. Encryption and decryption are the same operation from the same starting positions. The block sits between the symbol source and the result display/logging stage.

---
 rtl/enigma_rotor_engine.sv | 146 ++++++++++++++
 tb/tb_enigma_rotor_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor_engine.sv
// -----------------------------------------------------------------------------
// enigma_rotor_engine
//
// Clocked N-rotor, 2^W-symbol Enigma-style substitution cipher with a
// valid/ready stream interface and a 1-deep registered output buffer.
// Each accepted symbol first steps the rotors, then passes forward through
// the rotors, through a complementing reflector, and back. Because the
// reflector is a fixed-point-free involution, encryption and decryption are
// the same operation from the same starting positions, and a symbol never
// maps to itself.
//
// Parameters:
//   W    symbol width in bits (alphabet size 2^W), W >= 2
//   N    number of rotors, N >= 2
//   KEY  packed per-rotor keys, K_i = KEY[i*W +: W]
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load       load rotor positions from load_pos (wins over in_valid)
//   load_pos   new rotor positions, rotor i at [i*W +: W]
//   in_valid   in_sym is valid
//   in_ready   a symbol is accepted this cycle if in_valid is high
//   in_sym     plaintext or ciphertext symbol
//   out_valid  out_sym holds a result
//   out_ready  downstream accepts out_sym
//   out_sym    transformed symbol
//   pos        current rotor positions, same packing as load_pos
//
// Build option:
//   ENIGMA_DOUBLE_STEP_EN  when defined, middle rotors reproduce the
//                          historical double-step anomaly; otherwise the
//                          rotors step like a plain odometer.
// -----------------------------------------------------------------------------
module enigma_rotor_engine #(
  parameter int               W   = 4,
  parameter int               N   = 3,
  parameter logic [W*N-1:0]   KEY = 12'h9C5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [N*W-1:0] load_pos,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_sym,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_sym,
  output logic [N*W-1:0] pos
);

  // Every rotor turns over its neighbour when it sits at all ones.
  localparam logic [W-1:0] NOTCH = '1;

  // Next rotor positions, evaluated entirely on the pre-step positions.
  function automatic logic [N*W-1:0] step_rotors(input logic [N*W-1:0] p);
    logic [N-2:0]   at_notch;
    logic [N-1:0]   steps;
    logic [N*W-1:0] r;
    for (int i = 0; i < N - 1; i++) begin
      at_notch[i] = (p[i*W +: W] == NOTCH);
    end
    steps[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
`ifdef ENIGMA_DOUBLE_STEP_EN
      steps[i] = at_notch[i-1];
`else
      // Odometer: rotor i turns only when every faster rotor is at notch.
      steps[i] = steps[i-1] && at_notch[i-1];
`endif
    end
`ifdef ENIGMA_DOUBLE_STEP_EN
    // A middle rotor sitting at its own notch drags itself along with the
    // next rotor; the last rotor has no pawl of its own and never does.
    for (int i = 1; i < N - 1; i++) begin
      steps[i] = steps[i] | at_notch[i];
    end
`endif
    for (int i = 0; i < N; i++) begin
      r[i*W +: W] = p[i*W +: W] + {{(W-1){1'b0}}, steps[i]};
    end
    return r;
  endfunction

  // Forward pass, reflector (bitwise complement), reverse pass. The reverse
  // pass undoes each rotor's forward stage, so the whole path is an
  // involution for fixed positions.
  function automatic logic [W-1:0] transform(input logic [W-1:0]   sym,
                                             input logic [N*W-1:0] p);
    // NOTE: functions and always_comb use blocking '=' so each statement sees
    // the value produced by the previous one; registers use '<=' only.
    logic [W-1:0] s;
    s = sym;
    for (int i = 0; i < N; i++) begin
      s = (s + p[i*W +: W]) ^ KEY[i*W +: W];
    end
    s = ~s;
    for (int i = N - 1; i >= 0; i--) begin
      s = (s ^ KEY[i*W +: W]) - p[i*W +: W];
    end
    return s;
  endfunction

  logic           out_valid_q;
  logic [W-1:0]   out_sym_q;
  logic [N*W-1:0] pos_q;

  logic           accept;
  logic [N*W-1:0] pos_d;
  logic [W-1:0]   out_sym_d;

  // Load blocks acceptance; otherwise accept whenever the buffer is empty or
  // being drained this same cycle (no bubble at full throughput).
  assign in_ready = !load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets an unconditional assignment first,
    // so no path leaves it unassigned and no latch is inferred.
    pos_d     = step_rotors(pos_q);
    out_sym_d = transform(in_sym, pos_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      pos_q       <= '0;
    end else if (load) begin
      // Output buffer is left untouched while positions are loaded.
      pos_q <= load_pos;
    end else if (accept) begin
      pos_q       <= pos_d;
      out_valid_q <= 1'b1;
      out_sym_q   <= out_sym_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_enigma_rotor_engine.sv
// -----------------------------------------------------------------------------
// tb_enigma_rotor_engine
//
// Scoreboard bench for enigma_rotor_engine (W=4, N=3, KEY=12'h9C5).
// The driver pushes the reference model's expected result whenever a symbol
// is accepted; an independent monitor pops and compares whenever the DUT
// hands a symbol downstream. The reference model treats positions as plain
// integers (odometer stepping is a 12-bit increment) and computes the cipher
// with modular integer arithmetic.
// -----------------------------------------------------------------------------
module tb_enigma_rotor_engine;

  localparam int W = 4;
  localparam int N = 3;
  localparam logic [11:0] KEY = 12'h9C5;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [11:0] load_pos;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sym;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_sym;
  logic [11:0] pos;

  enigma_rotor_engine #(.W(W), .N(N), .KEY(KEY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_pos  (load_pos),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .pos       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sym;
    int pos;
    int in_sym;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  bit   rand_ready = 1'b0;

  // Reference model state: rotor positions as integers 0..15.
  int mp[3];
  int key[3] = '{5, 12, 9};

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int model_pack();
    return mp[0] + 16 * mp[1] + 256 * mp[2];
  endfunction

  function automatic void model_set(input int v);
    mp[0] = v % 16;
    mp[1] = (v / 16) % 16;
    mp[2] = (v / 256) % 16;
  endfunction

  function automatic void model_step();
`ifdef ENIGMA_DOUBLE_STEP_EN
    bit s1, s2;
    s1 = (mp[0] == 15) || (mp[1] == 15);
    s2 = (mp[1] == 15);
    mp[0] = (mp[0] + 1) % 16;
    if (s1) mp[1] = (mp[1] + 1) % 16;
    if (s2) mp[2] = (mp[2] + 1) % 16;
`else
    model_set((model_pack() + 1) % 4096);
`endif
  endfunction

  function automatic int model_cipher(input int sym);
    int s;
    s = sym;
    for (int i = 0; i < 3; i++) s = ((s + mp[i]) % 16) ^ key[i];
    s = 15 - s;
    for (int i = 2; i >= 0; i--) s = ((s ^ key[i]) - mp[i] + 16) % 16;
    return s;
  endfunction

  task automatic model_accept(input int sym, output int c);
    model_step();
    c = model_cipher(sym);
    sb.push_back('{c, model_pack(), sym});
  endtask

  // Monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_out: got %0h, expected no output", out_sym);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sym", out_sym, e.sym);
        check("out_pos", pos, e.pos);
        check("out_ne_in", int'(out_sym != 4'(e.in_sym)), 1);
      end
    end
  end

  // Random downstream backpressure when enabled.
  always @(negedge clk) begin
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input int sym, output int c);
    bit done;
    done = 1'b0;
    c = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sym   = 4'(sym);
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        model_accept(sym, c);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      chk_cnt++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    bit saved, empty;
    saved = rand_ready;
    rand_ready = 1'b0;
    empty = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !empty; n++) begin
      @(negedge clk);
      #1;
      empty = !out_valid;
    end
    if (!empty) begin
      chk_cnt++;
      $display("FAIL drain_timeout: got out_valid=1, expected 0 within 20 cycles");
    end
    rand_ready = saved;
  endtask

  task automatic load_rotors(input int p);
    bit saved;
    drain();
    saved = rand_ready;
    rand_ready = 1'b0;
    @(negedge clk);
    load     = 1'b1;
    load_pos = 12'(p);
    @(posedge clk);
    #1;
    load = 1'b0;
    model_set(p);
    rand_ready = saved;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_set(0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    int held_pos, held_sym;
    int p;
    int ct[16];

    rst_n = 1'b0;
    load = 1'b0;
    load_pos = '0;
    in_valid = 1'b0;
    in_sym = '0;
    out_ready = 1'b0;
    model_set(0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_pos", pos, 0);
    rst_n = 1'b1;

    // Basic encrypt from reset positions.
    out_ready = 1'b0;
    send(0, c);
    check("basic_valid", out_valid, 1);
    check("basic_sym", out_sym, 4'hD);
    check("basic_pos", pos, 12'h001);
    drain();

    // Reciprocity from reset positions.
    do_reset();
    out_ready = 1'b0;
    send(4'hD, c);
    check("recip_sym", out_sym, 4'h0);
    check("recip_pos", pos, 12'h001);
    drain();

    // Double-step / odometer behaviour.
    load_rotors(12'h0F0);
    check("load_pos", pos, 12'h0F0);
    send(5, c);
`ifdef ENIGMA_DOUBLE_STEP_EN
    check("dstep_pos", pos, 12'h101);
`else
    check("dstep_pos", pos, 12'h0F1);
`endif

    // Full wrap.
    load_rotors(12'hFFF);
    send(9, c);
    check("wrap_pos", pos, 12'h000);

    // Backpressure: second symbol waits until downstream is ready.
    load_rotors(12'h123);
    out_ready = 1'b0;
    send(7, c);
    held_pos = model_pack();
    held_sym = c;
    @(negedge clk);
    in_valid = 1'b1;
    in_sym   = 4'h9;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_pos", pos, held_pos);
      check("bp_sym", out_sym, held_sym);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk);
    model_accept(9, c);
    #1;
    in_valid = 1'b0;
    check("bp_release_pos", pos, model_pack());
    drain();

    // Asynchronous reset while a result is buffered.
    out_ready = 1'b0;
    send(3, c);
    check("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sym", out_sym, 0);
    check("async_rst_pos", pos, 0);
    sb.delete();
    model_set(0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load wins over a simultaneous in_valid.
    drain();
    @(negedge clk);
    load     = 1'b1;
    load_pos = 12'hABC;
    in_valid = 1'b1;
    in_sym   = 4'h2;
    #1;
    check("ld_prio_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    load = 1'b0;
    in_valid = 1'b0;
    model_set(12'hABC);
    check("ld_prio_pos", pos, 12'hABC);
    check("ld_prio_no_out", out_valid, 0);

    // Back-to-back random symbols at full throughput.
    out_ready = 1'b1;
    for (int n = 0; n < 24; n++) send(int'($urandom_range(0, 15)), c);
    check("burst_pos", pos, model_pack());

    // Reciprocity sweep from random positions with random backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      p = int'($urandom_range(0, 4095));
      load_rotors(p);
      for (int s = 0; s < 16; s++) send(s, ct[s]);
      load_rotors(p);
      for (int s = 0; s < 16; s++) begin
        send(ct[s], c);
        check("sweep_roundtrip", c, s);
      end
    end
    rand_ready = 1'b0;

    drain();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
